// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM for the multicycle MIPS datapath
//
// Purpose: sequences fetch, decode, execute, memory and writeback for RTYPE, LW,
//   SW, BEQ, ADDI, J, LUI, LI and BLT. Outputs are Moore-decoded from the state,
//   except the FETCH irwrite/pcwrite strobes, which are gated by the memory
//   ready handshake.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset; all outputs forced to 0 while low
//   op         instr[31:26] from the instruction register (valid from DECODE on)
//   mem_ready  memory completes the current access this cycle
//   pcwrite, branch, blt, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb[2:0], pcsrc[1:0], aluop[2:0]   datapath controls
//   illegal    one-cycle pulse on an unsupported opcode
module multicycle_ctrl #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       blt,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLT   = 6'b011111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LI    = 6'b010001;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_ADDIEX  = 4'd8,
    S_IMMEX   = 4'd9,
    S_IMMWB   = 4'd10,
    S_BEQEX   = 4'd11,
    S_BLTEX   = 4'd12,
    S_JEX     = 4'd13,
    S_ILLEGAL = 4'd14
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic       ready;

  assign ready = USE_MEM_READY ? mem_ready : 1'b1;

  // Opcode is captured on DECODE exit so later states ignore changes on op.
  assign op_d = (state_q == S_DECODE) ? op : op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    blt      = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 3'b000;
    pcsrc    = 2'b00;
    aluop    = 3'b000;
    illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        alusrcb = 3'b001;
        irwrite = ready;
        pcwrite = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 3'b011;
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_RTYPE:       state_d = S_RTYPEEX;
          OP_BEQ:         state_d = S_BEQEX;
          OP_BLT:         state_d = S_BLTEX;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_LUI, OP_LI:  state_d = S_IMMEX;
          OP_J:           state_d = S_JEX;
          default:        state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 3'b010;
        state_d = S_IMMWB;
      end
      S_IMMEX: begin
        aluop   = 3'b100;
        alusrcb = (op_q == OP_LUI) ? 3'b100 : 3'b101;
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 3'b001;
        branch  = 1'b1;
        pcsrc   = 2'b01;
        state_d = S_FETCH;
      end
      S_BLTEX: begin
        alusrca = 1'b1;
        aluop   = 3'b001;
        blt     = 1'b1;
        pcsrc   = 2'b01;
        state_d = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset is asynchronous at the outputs too: a stalled memwrite must drop
    // the moment reset asserts, not at the next edge.
    if (!reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      blt      = 1'b0;
      iord     = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      regwrite = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 3'b000;
      pcsrc    = 2'b00;
      aluop    = 3'b000;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       blt;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    ctrl_t w;
    bit    waits;
    bit    fetch;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, blt, iord, memwrite, irwrite;
  logic       regdst, memtoreg, regwrite, alusrca, illegal;
  logic [2:0] alusrcb, aluop;
  logic [1:0] pcsrc;
  ctrl_t      obs;

  int checks = 0;
  int errors = 0;
  int mw_cnt;
  step_t plan[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(.USE_MEM_READY(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .branch(branch), .blt(blt), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
  );

  always_comb begin
    obs          = '0;
    obs.pcwrite  = pcwrite;
    obs.branch   = branch;
    obs.blt      = blt;
    obs.iord     = iord;
    obs.memwrite = memwrite;
    obs.irwrite  = irwrite;
    obs.regdst   = regdst;
    obs.memtoreg = memtoreg;
    obs.regwrite = regwrite;
    obs.alusrca  = alusrca;
    obs.alusrcb  = alusrcb;
    obs.pcsrc    = pcsrc;
    obs.aluop    = aluop;
    obs.illegal  = illegal;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input ctrl_t w, input bit waits, input bit fetch);
    step_t s;
    s.w = w; s.waits = waits; s.fetch = fetch;
    plan.push_back(s);
  endfunction

  // Per-instruction list of cycles, as the datapath should see them.
  function automatic void build_plan(input logic [5:0] iop);
    ctrl_t c;
    plan.delete();
    c = '0; c.alusrcb = 3'b001; c.irwrite = 1; c.pcwrite = 1; push(c, 1, 1);
    c = '0; c.alusrcb = 3'b011; push(c, 0, 0);
    case (iop)
      6'b100011: begin
        c = '0; c.alusrca = 1; c.alusrcb = 3'b010; push(c, 0, 0);
        c = '0; c.iord = 1; push(c, 1, 0);
        c = '0; c.memtoreg = 1; c.regwrite = 1; push(c, 0, 0);
      end
      6'b101011: begin
        c = '0; c.alusrca = 1; c.alusrcb = 3'b010; push(c, 0, 0);
        c = '0; c.iord = 1; c.memwrite = 1; push(c, 1, 0);
      end
      6'b000000: begin
        c = '0; c.alusrca = 1; c.aluop = 3'b010; push(c, 0, 0);
        c = '0; c.regdst = 1; c.regwrite = 1; push(c, 0, 0);
      end
      6'b001000: begin
        c = '0; c.alusrca = 1; c.alusrcb = 3'b010; push(c, 0, 0);
        c = '0; c.regwrite = 1; push(c, 0, 0);
      end
      6'b001111, 6'b010001: begin
        c = '0; c.aluop = 3'b100; c.alusrcb = (iop == 6'b001111) ? 3'b100 : 3'b101; push(c, 0, 0);
        c = '0; c.regwrite = 1; push(c, 0, 0);
      end
      6'b000100, 6'b011111: begin
        c = '0; c.alusrca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01;
        if (iop == 6'b000100) c.branch = 1; else c.blt = 1;
        push(c, 0, 0);
      end
      6'b000010: begin
        c = '0; c.pcsrc = 2'b10; c.pcwrite = 1; push(c, 0, 0);
      end
      default: begin
        c = '0; c.illegal = 1; push(c, 0, 0);
      end
    endcase
  endfunction

  function automatic int base_latency(input logic [5:0] iop);
    case (iop)
      6'b100011:                                   return 5;
      6'b101011, 6'b000000, 6'b001000,
      6'b001111, 6'b010001:                        return 4;
      default:                                     return 3;
    endcase
  endfunction

  // Runs one instruction starting just after a rising edge in FETCH.
  // forced < 0: waiting cycles stall randomly with probability stall_pct;
  // forced >= 0: fetch never stalls, memory access stalls exactly forced cycles.
  task automatic run_instr(input logic [5:0] iop, input int stall_pct, input int forced);
    ctrl_t exp;
    int cycles = 0;
    int stalls = 0;
    mw_cnt = 0;
    build_plan(iop);
    foreach (plan[i]) begin
      int tries = 0;
      bit done = 0;
      while (!done) begin
        op = plan[i].fetch ? 6'($urandom) : iop;
        if (!plan[i].waits)
          mem_ready = 1'($urandom);
        else if (forced >= 0)
          mem_ready = (plan[i].fetch || tries >= forced) ? 1'b1 : 1'b0;
        else
          mem_ready = (tries < 3 && $urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
        exp = plan[i].w;
        if (plan[i].waits && !mem_ready && plan[i].fetch) begin
          exp.irwrite = 0;
          exp.pcwrite = 0;
        end
        @(negedge clk);
        check_eq("ctrl", 32'(obs), 32'(exp));
        check_eq("one_pc_write", 32'($countones({pcwrite, branch, blt}) <= 1), 32'd1);
        check_eq("rw_mw_excl", 32'(regwrite & memwrite), 32'd0);
        if (memwrite) mw_cnt++;
        done = !(plan[i].waits && !mem_ready);
        if (!done) stalls++;
        tries++;
        cycles++;
        @(posedge clk);
        #1;
      end
    end
    check_eq("latency", 32'(cycles), 32'(base_latency(iop) + stalls));
  endtask

  // Runs up to step k, stalls there, then asserts reset mid-access.
  task automatic abort_in(input logic [5:0] iop, input int k);
    build_plan(iop);
    for (int i = 0; i < k; i++) begin
      op = iop;
      mem_ready = 1'b1;
      @(negedge clk);
      check_eq("pre_abort", 32'(obs), 32'(plan[i].w));
      @(posedge clk);
      #1;
    end
    op = iop;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("stall_word", 32'(obs), 32'(plan[k].w));
    reset = 1'b0;
    #1;
    check_eq("async_zero", 32'(obs), 32'd0);
    check_eq("async_memwrite", 32'(memwrite), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    logic [5:0] legal[9];
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b011111,
              6'b001000, 6'b001111, 6'b010001, 6'b000010};
    reset = 1'b0;
    op = '0;
    mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("reset_outputs", 32'(obs), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 0, 2);
    check_eq("sw_memwrite_cycles", 32'(mw_cnt), 32'd3);
    run_instr(6'b011111, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b001111, 0, 0);
    run_instr(6'b010001, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b000010, 0, 0);

    abort_in(6'b100011, 3);
    run_instr(6'b000000, 0, 0);
    abort_in(6'b101011, 3);
    run_instr(6'b100011, 30, -1);

    for (int n = 0; n < 200; n++) begin
      logic [5:0] iop;
      if ($urandom_range(9) == 0) iop = 6'($urandom);
      else iop = legal[$urandom_range(8)];
      run_instr(iop, 30, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
